hazard_control_unit: RTL
========================

# hazard_control_unit

Pipeline hazard controller for the five-stage MIPS datapath. It sits directly upstream of the 9-bit ID-stage control mux: its `CtrlSel` output drives that mux's select. `CtrlSel=1` picks the all-zero bubble input (inB) and `CtrlSel=0` passes decoded control (inA). It also issues PC/IF-ID write enables, the IF/ID flush, and a multi-cycle freeze when a multiply occupies EX.

## Interface
Parameters:
- `MUL_LAT`, 4, total EX-occupancy cycles of a multiply; legal values ≥ 1; freeze length F = MUL_LAT−1.

Ports:
- `Clk`  in  1  system clock; all state updates on rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `IFID_Rs`, `IFID_Rt`  in  5 each  source registers of the instruction in ID.
- `IFID_UsesRt`  in  1  ID instruction reads Rt (R-type, store, branch).
- `IDEX_MemRead`  in  1  instruction in EX is a load.
- `IDEX_RegWrite`  in  1  instruction in EX writes a register.
- `IDEX_WriteReg`  in  5  destination of the EX instruction.
- `EXMEM_MemRead`  in  1  instruction in MEM is a load.
- `EXMEM_WriteReg`  in  5  destination of the MEM instruction.
- `ID_Branch`  in  1  branch in ID; compare is done in ID.
- `ID_Jump`  in  1  jump decoded in ID.
- `BranchTaken`  in  1  ID compare result; valid only with `ID_Branch`.
- `MulStart`  in  1  single-cycle pulse when a multiply first enters EX.
- `PCWrite`  out  1  PC load enable.
- `IFIDWrite`  out  1  IF/ID load enable.
- `IFIDFlush`  out  1  zero the IF/ID register next edge.
- `CtrlSel`  out  1  control-mux select; 1 inserts a bubble into ID/EX.
- `IDEXWrite`  out  1  ID/EX load enable.
- `Busy`  out  1  EX frozen by a multiply; downstream bubbles EX/MEM.

## Operation
- `match(r)` = `(r≠0) & (r==IFID_Rs | (IFID_UsesRt & r==IFID_Rt))`.
- LU = `IDEX_MemRead & match(IDEX_WriteReg)`.
- BR1 = `ID_Branch & IDEX_RegWrite & match(IDEX_WriteReg)`.
- BR2 = `ID_Branch & EXMEM_MemRead & match(EXMEM_WriteReg)`.
- stall = LU | BR1 | BR2. Re-evaluated every cycle, so a load feeding a branch stalls 2 cycles naturally.
- Redirect = `!stall & (ID_Jump | (ID_Branch & BranchTaken))`. There is no delay slot.

FSM states: RUN and MUL_BUSY. There is also a counter `cnt`, 0..MUL_LAT−2.

Output priority (highest first):
1. **Freeze**: MUL_BUSY, or RUN with `MulStart` and F ≥ 1. Outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, IFIDFlush=0, CtrlSel=0, Busy=1.
2. **stall**: PCWrite=0, IFIDWrite=0, CtrlSel=1, IDEXWrite=1, IFIDFlush=0, Busy=0.
3. **Redirect**: PCWrite=1, IFIDWrite=1, IFIDFlush=1, CtrlSel=0, IDEXWrite=1.
4. **Normal**: all enables 1, IFIDFlush=0, CtrlSel=0, Busy=0.

Transitions:
- RUN & `MulStart` & F ≥ 2: `cnt` ← F−1, go to MUL_BUSY.
- RUN & `MulStart` & F = 1: stay in RUN (one frozen cycle only).
- F = 0: `MulStart` is ignored.
- MUL_BUSY: `cnt` ← `cnt`−1; when `cnt`==1, go to RUN next edge.
- `MulStart` is ignored while in MUL_BUSY.

## Timing
- Outputs are combinational (Mealy) from state plus same-cycle inputs. There is no added latency; the stall is visible in the same cycle as the hazard.
- A multiply freezes exactly F consecutive cycles, counting the `MulStart` cycle.
- Reset (`Rst`=0, asynchronous): state=RUN, `cnt`=0. Outputs are forced to PCWrite=0, IFIDWrite=0, IDEXWrite=0, IFIDFlush=1, CtrlSel=1, Busy=0, independent of other inputs.
- The first rising edge after `Rst` rises runs normally.
- Reset mid-freeze aborts the freeze immediately; no residual Busy after release.
- Simultaneous stall and redirect: stall wins, and the branch is re-evaluated next cycle.
- Simultaneous freeze and hazard: freeze wins, and the hazard is re-evaluated after release.

## Structure
- Shared package `hazard_pkg` holds:
  - state encoding RUN=1'b0, MUL_BUSY=1'b1;
  - `REG_ZERO`=5'd0;
  - `MUL_LAT_DEFAULT`=4.
- One sub-module, `mul_freeze_counter`:
  - contains `cnt`, the FSM and the `Busy` generation;
  - the top level contains the hazard equations and the output priority mux.

## Test plan
- Reset asserted mid-stream, async and off-edge → outputs 0/0/0/1/1/0 immediately; release → next cycle PCWrite=IFIDWrite=IDEXWrite=1, CtrlSel=0.
- `lw $5` in EX, `add $3,$5,$2` in ID → one cycle of CtrlSel=1, PCWrite=0, IFIDWrite=0; next cycle normal. Same case with destination $0 → no stall.
- `lw $4` in EX, `beq $4,$1` in ID → 2 stall cycles (LU, then BR2), then redirect with IFIDFlush=1 if BranchTaken=1.
- `ID_Jump`=1, no hazard → IFIDFlush=1, PCWrite=1, CtrlSel=0 for one cycle.
- MUL_LAT=4, `MulStart` pulse → Busy=1 and all enables 0 for exactly 3 cycles. A second `MulStart` in cycle 2 has no effect. A load-use hazard present throughout stalls 1 cycle after release.
- MUL_LAT=2 → Busy for 1 cycle, FSM never leaves RUN. MUL_LAT=1 → `MulStart` ignored.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MUL_LAT_DEFAULT = 4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic ctrl_sel;
        logic idex_write;
        logic busy;
    } hz_ctrl_t;

    // True when a nonzero destination feeds a source the ID instruction actually reads.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/mul_freeze_counter.sv
// Tracks multiply occupancy of EX; busy is high for MUL_LAT-1 cycles from the start pulse.
module mul_freeze_counter
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mul_start,
    output logic busy
);

    localparam int F  = MUL_LAT - 1;
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = (F >= 2) ? CW'(F - 1) : '0;

    mul_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The start cycle itself is frozen, so BUSY only covers the remaining F-1 cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            RUN: begin
                if (mul_start && (F >= 1)) busy = 1'b1;
                if (mul_start && (F >= 2)) begin
                    cnt_nxt   = CNT_INIT;
                    state_nxt = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy    = 1'b1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-operand stall detection, ID-stage redirect and multiply freeze priority mux.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic [4:0] IDEX_WriteReg,
    input  logic       EXMEM_MemRead,
    input  logic [4:0] EXMEM_WriteReg,
    input  logic       ID_Branch,
    input  logic       ID_Jump,
    input  logic       BranchTaken,
    input  logic       MulStart,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       CtrlSel,
    output logic       IDEXWrite,
    output logic       Busy
);

    logic     freeze, match_ex, match_mem, load_use, br_ex, br_mem, stall, redirect;
    hz_ctrl_t ctrl;

    mul_freeze_counter #(.MUL_LAT(MUL_LAT)) u_mul (
        .clk       (Clk),
        .rst_n     (Rst),
        .mul_start (MulStart),
        .busy      (freeze)
    );

    assign match_ex  = reg_match(IDEX_WriteReg,  IFID_Rs, IFID_Rt, IFID_UsesRt);
    assign match_mem = reg_match(EXMEM_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
    assign load_use  = IDEX_MemRead & match_ex;
    // Branches compare in ID, so even ALU results in EX and loads in MEM arrive too late.
    assign br_ex     = ID_Branch & IDEX_RegWrite & match_ex;
    assign br_mem    = ID_Branch & EXMEM_MemRead & match_mem;
    assign stall     = load_use | br_ex | br_mem;
    assign redirect  = !stall & (ID_Jump | (ID_Branch & BranchTaken));

    always_comb begin
        ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                 ctrl_sel: 1'b0, idex_write: 1'b1, busy: 1'b0};
        if (!Rst)
            ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                     ctrl_sel: 1'b1, idex_write: 1'b0, busy: 1'b0};
        else if (freeze)
            ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                     ctrl_sel: 1'b0, idex_write: 1'b0, busy: 1'b1};
        else if (stall)
            ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                     ctrl_sel: 1'b1, idex_write: 1'b1, busy: 1'b0};
        else if (redirect)
            ctrl.ifid_flush = 1'b1;
    end

    assign PCWrite   = ctrl.pc_write;
    assign IFIDWrite = ctrl.ifid_write;
    assign IFIDFlush = ctrl.ifid_flush;
    assign CtrlSel   = ctrl.ctrl_sel;
    assign IDEXWrite = ctrl.idex_write;
    assign Busy      = ctrl.busy;

endmodule
